hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS datapath. It carries the control-unit bundles (EX 5b, M 3b, WB 2b) through the ID/EX, EX/MEM and MEM/WB stage registers. It detects load-use hazards and inserts bubbles, flushes on taken branches, and generates ALU-operand forwarding selects. It sits between the control unit's outputs and the stage control inputs, and also drives PC and IF/ID write enables.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/fwd_unit.sv | 25 ++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared field positions, forwarding encodings and bubble values for the
// pipeline sequencing controller.
package pipe_pkg;

  localparam int EX_W = 5;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  localparam int EX_REGDST   = 0;
  localparam int M_BRANCH    = 0;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 2;
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [EX_W-1:0] EX_BUBBLE = '0;
  localparam logic [M_W-1:0]  M_BUBBLE  = '0;
  localparam logic [WB_W-1:0] WB_BUBBLE = '0;

  // MemToReg=0 selects memory data, so a load writes a register from memory.
  function automatic logic is_load(input logic [M_W-1:0] m, input logic [WB_W-1:0] wb);
    return m[M_MEMREAD] & wb[WB_REGWRITE] & ~wb[WB_MEMTOREG];
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Control-unit side bundle of the pipeline sequencing controller: ID fields in,
// stage controls, enables, forwarding selects and event counters out.
interface hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic [EX_W-1:0]  id_ex;
  logic [M_W-1:0]   id_m;
  logic [WB_W-1:0]  id_wb;
  logic             ex_zero;

  logic [EX_W-1:0]  ex_ctrl;
  logic [M_W-1:0]   mem_ctrl;
  logic [WB_W-1:0]  wb_ctrl;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             pc_src;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_ex, id_m, id_wb, ex_zero,
    input  ex_ctrl, mem_ctrl, wb_ctrl, pc_we, ifid_we, ifid_flush, pc_src,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_ex, id_m, id_wb, ex_zero,
    output ex_ctrl, mem_ctrl, wb_ctrl, pc_we, ifid_we, ifid_flush, pc_src,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fwd_unit.sv
// ALU operand forwarding select for one source register; the younger EX/MEM
// result always takes precedence over MEM/WB.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             exmem_rw,
  input  logic [REG_W-1:0] exmem_dest,
  input  logic             memwb_rw,
  input  logic [REG_W-1:0] memwb_dest,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (exmem_rw && (exmem_dest != '0) && (exmem_dest == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_rw && (memwb_dest != '0) && (memwb_dest == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Carries EX/M/WB control bundles through ID/EX, EX/MEM and MEM/WB, inserts
// load-use bubbles, squashes on taken branches and drives forwarding selects.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [EX_W-1:0]  idex_ex;
  logic [M_W-1:0]   idex_m;
  logic [WB_W-1:0]  idex_wb;
  logic [REG_W-1:0] idex_rs;
  logic [REG_W-1:0] idex_rt;
  logic [REG_W-1:0] idex_dest;

  logic [M_W-1:0]   exmem_m;
  logic [WB_W-1:0]  exmem_wb;
  logic [REG_W-1:0] exmem_dest;

  logic [WB_W-1:0]  memwb_wb;
  logic [REG_W-1:0] memwb_dest;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic             taken;
  logic             load_use;
  logic             stall;
  logic             id_bad;
  logic             bubble;
  logic [WB_W-1:0]  id_wb_clean;
  logic [REG_W-1:0] id_dest;

  always_comb begin
    taken       = idex_m[M_BRANCH] & bus.ex_zero;
    load_use    = is_load(idex_m, idex_wb) && (idex_dest != '0) &&
                  ((idex_dest == bus.id_rs) || (idex_dest == bus.id_rt));
    // A taken branch squashes the dependent instruction anyway, so no stall.
    stall       = load_use & ~taken;
    id_bad      = ~bus.id_valid | $isunknown({bus.id_ex, bus.id_m, bus.id_wb});
    bubble      = id_bad | stall | taken;
    id_wb_clean = bus.id_wb;
    id_wb_clean[WB_REGWRITE] = bus.id_wb[WB_REGWRITE] & ~bus.id_m[M_MEMWRITE];
    id_dest     = bus.id_ex[EX_REGDST] ? bus.id_rd : bus.id_rt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_ex    <= EX_BUBBLE;
      idex_m     <= M_BUBBLE;
      idex_wb    <= WB_BUBBLE;
      idex_rs    <= '0;
      idex_rt    <= '0;
      idex_dest  <= '0;
      exmem_m    <= M_BUBBLE;
      exmem_wb   <= WB_BUBBLE;
      exmem_dest <= '0;
      memwb_wb   <= WB_BUBBLE;
      memwb_dest <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      if (bubble) begin
        idex_ex   <= EX_BUBBLE;
        idex_m    <= M_BUBBLE;
        idex_wb   <= WB_BUBBLE;
        idex_rs   <= '0;
        idex_rt   <= '0;
        idex_dest <= '0;
      end else begin
        idex_ex   <= bus.id_ex;
        idex_m    <= bus.id_m;
        idex_wb   <= id_wb_clean;
        idex_rs   <= bus.id_rs;
        idex_rt   <= bus.id_rt;
        idex_dest <= id_dest;
      end
      exmem_m    <= idex_m;
      exmem_wb   <= idex_wb;
      exmem_dest <= idex_dest;
      memwb_wb   <= exmem_wb;
      memwb_dest <= exmem_dest;
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (taken && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_ONE;
      end
    end
  end

  fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .src        (idex_rs),
    .exmem_rw   (exmem_wb[WB_REGWRITE]),
    .exmem_dest (exmem_dest),
    .memwb_rw   (memwb_wb[WB_REGWRITE]),
    .memwb_dest (memwb_dest),
    .sel        (bus.fwd_a)
  );

  fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .src        (idex_rt),
    .exmem_rw   (exmem_wb[WB_REGWRITE]),
    .exmem_dest (exmem_dest),
    .memwb_rw   (memwb_wb[WB_REGWRITE]),
    .memwb_dest (memwb_dest),
    .sel        (bus.fwd_b)
  );

  assign bus.ex_ctrl    = idex_ex;
  assign bus.mem_ctrl   = exmem_m;
  assign bus.wb_ctrl    = memwb_wb;
  assign bus.pc_we      = ~stall;
  assign bus.ifid_we    = ~stall;
  assign bus.ifid_flush = taken;
  assign bus.pc_src     = taken;
  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: an instruction-slot model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what instruction occupies each stage, decoded into its control effects.
  typedef struct {
    logic [4:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
  } slot_t;

  slot_t s_idex, s_exmem, s_memwb;
  int    m_stall, m_flush;
  bit    live = 1'b0;

  function automatic slot_t empty_slot();
    slot_t s;
    s.ex = '0; s.m = '0; s.wb = '0; s.rs = '0; s.rt = '0; s.dest = '0;
    return s;
  endfunction

  function automatic slot_t decode_id();
    slot_t s;
    s = empty_slot();
    if (bus.id_valid === 1'b1 && !$isunknown({bus.id_ex, bus.id_m, bus.id_wb})) begin
      s.ex   = bus.id_ex;
      s.m    = bus.id_m;
      s.wb   = bus.id_wb;
      if (bus.id_m[2]) s.wb[0] = 1'b0;
      s.rs   = bus.id_rs;
      s.rt   = bus.id_rt;
      s.dest = bus.id_ex[0] ? bus.id_rd : bus.id_rt;
    end
    return s;
  endfunction

  function automatic bit m_taken();
    return s_idex.m[0] && bus.ex_zero;
  endfunction

  function automatic bit m_stall_now();
    bit is_ld;
    is_ld = s_idex.wb[0] && s_idex.m[1] && !s_idex.wb[1];
    return is_ld && (s_idex.dest != '0) &&
           (s_idex.dest == bus.id_rs || s_idex.dest == bus.id_rt) && !m_taken();
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (s_exmem.wb[0] && s_exmem.dest != '0 && s_exmem.dest == src) return 2'b10;
    if (s_memwb.wb[0] && s_memwb.dest != '0 && s_memwb.dest == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      s_idex  = empty_slot();
      s_exmem = empty_slot();
      s_memwb = empty_slot();
      m_stall = 0;
      m_flush = 0;
      live    = 1'b1;
    end else if (live) begin
      bit st, tk;
      st = m_stall_now();
      tk = m_taken();
      s_memwb = s_exmem;
      s_exmem = s_idex;
      s_idex  = (st || tk) ? empty_slot() : decode_id();
      if (st && m_stall < CMAX) m_stall++;
      if (tk && m_flush < CMAX) m_flush++;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model ex_ctrl",    32'(bus.ex_ctrl),    32'(s_idex.ex));
      chk("model mem_ctrl",   32'(bus.mem_ctrl),   32'(s_exmem.m));
      chk("model wb_ctrl",    32'(bus.wb_ctrl),    32'(s_memwb.wb));
      chk("model pc_we",      32'(bus.pc_we),      32'(!m_stall_now()));
      chk("model ifid_we",    32'(bus.ifid_we),    32'(!m_stall_now()));
      chk("model ifid_flush", 32'(bus.ifid_flush), 32'(m_taken()));
      chk("model pc_src",     32'(bus.pc_src),     32'(m_taken()));
      chk("model fwd_a",      32'(bus.fwd_a),      32'(m_fwd(s_idex.rs)));
      chk("model fwd_b",      32'(bus.fwd_b),      32'(m_fwd(s_idex.rt)));
      chk("model stall_cnt",  32'(bus.stall_cnt),  32'(m_stall));
      chk("model flush_cnt",  32'(bus.flush_cnt),  32'(m_flush));
    end
  end

  task automatic put(input int v, input int rs, input int rt, input int rd,
                     input int ex, input int m, input int wb, input int z);
    bus.id_valid = 1'(v);
    bus.id_rs    = 5'(rs);
    bus.id_rt    = 5'(rt);
    bus.id_rd    = 5'(rd);
    bus.id_ex    = 5'(ex);
    bus.id_m     = 3'(m);
    bus.id_wb    = 2'(wb);
    bus.ex_zero  = 1'(z);
  endtask

  task automatic lw(input int rt);        put(1, 0, rt, rt, 5'b00001, 3'b010, 2'b01, 0); endtask
  task automatic add(input int rs, input int rt, input int rd);
                                          put(1, rs, rt, rd, 5'b00101, 3'b000, 2'b11, 0); endtask
  task automatic idle();                  put(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic step();                  @(posedge clk); #1; endtask
  task automatic settle();                #3; endtask
  task automatic drain();                 idle(); repeat (3) step(); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with arbitrary inputs
    rst_n = 1'b0;
    put(1, 8, 8, 8, 5'b11111, 3'b111, 2'b11, 1);
    step(); step();
    settle();
    chk("reset ex_ctrl",   32'(bus.ex_ctrl),   0);
    chk("reset mem_ctrl",  32'(bus.mem_ctrl),  0);
    chk("reset wb_ctrl",   32'(bus.wb_ctrl),   0);
    chk("reset pc_we",     32'(bus.pc_we),     1);
    chk("reset ifid_we",   32'(bus.ifid_we),   1);
    chk("reset pc_src",    32'(bus.pc_src),    0);
    chk("reset flush",     32'(bus.ifid_flush), 0);
    chk("reset fwd_a",     32'(bus.fwd_a),     0);
    chk("reset stall_cnt", 32'(bus.stall_cnt), 0);
    chk("reset flush_cnt", 32'(bus.flush_cnt), 0);
    rst_n = 1'b1;
    idle();
    step();

    // Load-use: LW r8 then ADD using r8
    lw(8); step();
    add(8, 9, 10); settle();
    chk("lu stall pc_we",   32'(bus.pc_we),   0);
    chk("lu stall ifid_we", 32'(bus.ifid_we), 0);
    chk("lu stall ex_ctrl", 32'(bus.ex_ctrl), 32'(5'b00001));
    step(); settle();
    chk("lu bubble ex_ctrl", 32'(bus.ex_ctrl), 0);
    chk("lu bubble pc_we",   32'(bus.pc_we),   1);
    chk("lu stall_cnt",      32'(bus.stall_cnt), 1);
    step(); idle(); settle();
    chk("lu fwd_a memwb", 32'(bus.fwd_a), 32'(2'b01));
    chk("lu fwd_b rf",    32'(bus.fwd_b), 32'(2'b00));
    step(); drain();

    // EX/MEM wins over MEM/WB
    add(1, 2, 3); step();
    add(1, 2, 3); step();
    add(3, 3, 4); step();
    idle(); settle();
    chk("exmem fwd_a", 32'(bus.fwd_a), 32'(2'b10));
    chk("exmem fwd_b", 32'(bus.fwd_b), 32'(2'b10));
    step(); drain();

    // MEM/WB only
    add(1, 2, 4); step();
    idle(); step();
    add(4, 5, 6); step();
    idle(); settle();
    chk("memwb fwd_a", 32'(bus.fwd_a), 32'(2'b01));
    chk("memwb fwd_b", 32'(bus.fwd_b), 32'(2'b00));
    step(); drain();

    // Register $0 never forwards and never stalls
    add(1, 2, 0); step();
    add(0, 0, 7); settle();
    chk("r0 pc_we", 32'(bus.pc_we), 1);
    step(); idle(); settle();
    chk("r0 fwd_a", 32'(bus.fwd_a), 0);
    chk("r0 fwd_b", 32'(bus.fwd_b), 0);
    step();
    lw(0); step();
    add(0, 0, 7); settle();
    chk("r0 load pc_we", 32'(bus.pc_we), 1);
    chk("r0 load stall_cnt", 32'(bus.stall_cnt), 1);
    step(); drain();

    // Taken branch overrides a load-use pattern in ID
    put(1, 1, 9, 0, 5'b00010, 3'b011, 2'b01, 0); step();
    add(9, 2, 3); bus.ex_zero = 1'b1; settle();
    chk("br pc_src",     32'(bus.pc_src),     1);
    chk("br ifid_flush", 32'(bus.ifid_flush), 1);
    chk("br pc_we",      32'(bus.pc_we),      1);
    chk("br ifid_we",    32'(bus.ifid_we),    1);
    step(); idle(); settle();
    chk("br next ex_ctrl", 32'(bus.ex_ctrl),   0);
    chk("br flush_cnt",    32'(bus.flush_cnt), 1);
    chk("br stall_cnt",    32'(bus.stall_cnt), 1);
    step();
    put(1, 1, 2, 0, 5'b00010, 3'b001, 2'b00, 0); step();
    idle(); settle();
    chk("br nt pc_src", 32'(bus.pc_src), 0);
    step(); drain();

    // Store never writes the register file; X bundle becomes a bubble
    put(1, 1, 5, 5, 5'b10000, 3'b100, 2'b01, 0); step();
    add(5, 5, 6); step();
    bus.id_valid = 1'b1;
    bus.id_ex = 'x; bus.id_m = 'x; bus.id_wb = 'x;
    bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_rd = 5'd3;
    settle();
    chk("sw mem_ctrl", 32'(bus.mem_ctrl), 32'(3'b100));
    chk("sw fwd_a",    32'(bus.fwd_a),    0);
    chk("sw fwd_b",    32'(bus.fwd_b),    0);
    step(); idle(); settle();
    chk("sw wb_ctrl", 32'(bus.wb_ctrl), 0);
    chk("x ex_ctrl",  32'(bus.ex_ctrl), 0);
    step(); settle();
    chk("x mem_ctrl", 32'(bus.mem_ctrl), 0);
    step(); settle();
    chk("x wb_ctrl", 32'(bus.wb_ctrl), 0);
    step(); drain();

    // Counter saturation
    for (int i = 0; i < 16; i++) begin
      lw(8); step();
      add(8, 9, 10); step();
      idle(); step();
    end
    settle();
    chk("sat stall_cnt", 32'(bus.stall_cnt), CMAX);
    step(); drain();
    for (int i = 0; i < 15; i++) begin
      put(1, 1, 2, 0, 5'b00010, 3'b001, 2'b00, 0); step();
      idle(); bus.ex_zero = 1'b1; step();
      bus.ex_zero = 1'b0;
    end
    settle();
    chk("sat flush_cnt", 32'(bus.flush_cnt), CMAX);
    step(); drain();

    // Reset in the middle of a stall
    lw(8); step();
    add(8, 9, 10); settle();
    chk("rst mid pc_we before", 32'(bus.pc_we), 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    settle();
    chk("rst mid pc_we",     32'(bus.pc_we),     1);
    chk("rst mid ex_ctrl",   32'(bus.ex_ctrl),   0);
    chk("rst mid stall_cnt", 32'(bus.stall_cnt), 0);
    chk("rst mid flush_cnt", 32'(bus.flush_cnt), 0);
    step(); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
